// File: rtl/wave_generator.sv
// Periodic waveform generator: a prescaler drives a phase accumulator, and the
// accumulator phase is shaped into sawtooth, ramp-down, triangle or square.
module wave_generator #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [WIDTH-1:0]     step,
  output logic [WIDTH-1:0]     wave,
  output logic                 wrap
);

  localparam logic [DIV_WIDTH-1:0] PRESC_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] r_presc;
  logic [WIDTH-1:0]     r_acc;
  logic                 r_wrap_stg;

  logic                 w_tick;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_tri;
  logic [WIDTH-1:0]     w_shape;

  // >= rather than == so a div lowered below the running count ends the period at once
  assign w_tick = en && (r_presc >= div);
  assign w_sum  = {1'b0, r_acc} + {1'b0, step};
  assign w_tri  = {r_acc[WIDTH-2:0], 1'b0};

  always_comb begin
    w_shape = r_acc;
    unique case (mode)
      2'b00: w_shape = r_acc;
      2'b01: w_shape = ~r_acc;
      2'b10: w_shape = r_acc[WIDTH-1] ? ~w_tri : w_tri;
      2'b11: w_shape = {WIDTH{r_acc[WIDTH-1]}};
      default: w_shape = r_acc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc    <= '0;
      r_acc      <= '0;
      r_wrap_stg <= 1'b0;
    end else if (clr) begin
      r_presc    <= '0;
      r_acc      <= '0;
      r_wrap_stg <= 1'b0;
    end else begin
      if (en) r_presc <= w_tick ? '0 : r_presc + PRESC_ONE;
      if (w_tick) r_acc <= w_sum[WIDTH-1:0];
      r_wrap_stg <= w_tick && w_sum[WIDTH];
    end
  end

  // Output stage: wrap is delayed alongside wave so both mark the same sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wave <= '0;
      wrap <= 1'b0;
    end else begin
      wave <= w_shape;
      wrap <= r_wrap_stg;
    end
  end

endmodule

// File: doc/wave_generator.md
Name: wave_generator

Overview:
Parametrised periodic waveform generator; the next generation of the fixed 8-bit sawtooth frequency divider. It combines a programmable prescaler with a phase accumulator of configurable width and a run-time selectable output shape: sawtooth, ramp-down, triangle or square. Typical use is driving a DAC or audio/test-pattern path from the single system clock.

Parameters:
WIDTH, 8, bit width of the phase accumulator and of the wave output (must be >= 2)
DIV_WIDTH, 16, bit width of the prescaler divide value

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  run enable; low freezes prescaler and accumulator
clr  input  1  synchronous clear of prescaler and accumulator
mode  input  2  waveform select: 00 sawtooth, 01 ramp-down, 10 triangle, 11 square
div  input  DIV_WIDTH  prescaler terminal count; accumulator steps every div+1 enabled cycles
step  input  WIDTH  phase increment applied per prescaler tick
wave  output  WIDTH  registered waveform sample
wrap  output  1  one-cycle pulse marking the start of a new period, aligned with wave

Behaviour:
- Interface: one clock `clk`; `rst` is asynchronous and active-high. Assertion immediately forces `presc`, `acc`, `wave`, `wrap` and the internal wrap stage to 0.
- Prescaler `presc` (DIV_WIDTH bits):
  - When en=1 and presc >= div: internal `tick`=1 and presc <= 0.
  - When en=1 and presc < div: presc <= presc+1.
  - When en=0: presc holds and tick=0.
  - The >= compare makes a div reduced below the current presc terminate on the next enabled cycle.
  - div=0 gives tick on every enabled cycle.
- Accumulator `acc` (WIDTH bits):
  - On tick: acc <= (acc + step) mod 2^WIDTH.
  - Carry-out of that add sets the internal wrap stage to 1 for one cycle; otherwise the stage is 0.
  - step=0 freezes acc and never produces a carry.
- clr=1 (synchronous): presc <= 0, acc <= 0, internal wrap stage <= 0. clr has priority over tick; en is ignored while clr=1. wave continues to track acc normally.
- Output shaping, registered every clock, from the current acc and mode:
  - 00 sawtooth: wave <= acc
  - 01 ramp-down: wave <= ~acc
  - 10 triangle: t = {acc[WIDTH-2:0],1'b0}; wave <= acc[WIDTH-1] ? ~t : t
  - 11 square: wave <= acc[WIDTH-1] ? all ones : 0
- Latency:
  - Tick in cycle N updates acc at edge N+1 and wave at edge N+2.
  - A mode change is visible on wave one edge after it is sampled, with no glitch and no reset of acc.
- wrap output: the internal wrap stage delayed one more register, so wrap=1 in exactly the cycle wave first shows the post-wrap sample.
- Simultaneous events: rst overrides everything; then clr; then tick.
- Any mid-period change to div or step takes effect on the next tick with no restart.

Test Plan:
1. WIDTH=8, div=0, step=1, mode=00, en=1 after reset -> wave steps 0,1,2,...,255,0 one per cycle; wrap=1 only in the cycle wave returns to 0; period 256 cycles.
2. div=3, step=1, mode=00 -> wave increments every 4 cycles (0,0,0,0,1,1,1,1,...); a 20-cycle en=0 gap mid-run holds wave constant and resumes with the same remaining prescaler count.
3. step=1, mode=10, observe acc=64 -> wave=128; acc=127 -> 254; acc=192 -> 127; acc=255 -> 1. mode=01 with acc=5 -> wave=250.
4. div=0, step=64, mode=11 -> wave sequence 0,0,255,255 repeating; wrap pulses every 4 cycles, coincident with wave returning to 0.
5. Running at acc=100: pulse clr for one cycle -> acc=0 and wave=0 two edges later. Separately, assert rst asynchronously between edges -> wave=0 and wrap=0 immediately; normal counting resumes from 0 after release.
6. div=1000 while presc=500, change div to 10 -> tick on the next enabled cycle, then a regular 11-cycle cadence. Also change step from 1 to 3 mid-ramp -> increments of 3 from the next tick, with no discontinuity other than the step size.
